// File: rtl/stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : stage_sequencer
// Description : Multicycle IF/EX/MEM/HALT stage controller with memory
//               handshakes, multi-cycle execute and MEM timeout abort.
//               Define STAGE_SEQ_PERF_EN to build the performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module stage_sequencer #(
  parameter int EXC_W   = 3,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             imem_ready,
  input  logic             mem_inst,
  input  logic             halt_inst,
  input  logic [EXC_W-1:0] ex_cycles,
  input  logic             mem_ready,
  input  logic             run,
  output logic             ir_wen,
  output logic             ex_to_mem_wen,
  output logic             pc_wen,
  output logic             psr_wen,
  output logic             rf_wen,
  output logic [1:0]       stage,
  output logic             halted,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] stall_count
);

  localparam int                    c_WAIT_W  = $clog2(TIMEOUT + 1);
  localparam logic [c_WAIT_W-1:0]   c_TIMEOUT = c_WAIT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IF   = 2'd0,
    ST_EX   = 2'd1,
    ST_MEM  = 2'd2,
    ST_HALT = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [EXC_W-1:0]    r_ex_cnt;
  logic [EXC_W-1:0]    w_ex_cnt_nxt;
  logic [c_WAIT_W-1:0] r_wait_cnt;
  logic [c_WAIT_W-1:0] w_wait_nxt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= ST_IF;
      r_ex_cnt   <= '0;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_next;
      r_ex_cnt   <= w_ex_cnt_nxt;
      r_wait_cnt <= w_wait_nxt;
    end
  end

  // Reset forces r_state to IF asynchronously, so the IF decode below also
  // yields the required in-reset outputs (ir_wen tracks imem_ready).
  always_comb begin
    w_next        = r_state;
    w_ex_cnt_nxt  = r_ex_cnt;
    w_wait_nxt    = r_wait_cnt;
    ir_wen        = 1'b0;
    ex_to_mem_wen = 1'b0;
    pc_wen        = 1'b0;
    psr_wen       = 1'b0;
    rf_wen        = 1'b0;
    halted        = 1'b0;
    mem_timeout   = 1'b0;
    case (r_state)
      ST_IF: begin
        if (imem_ready) begin
          ir_wen = 1'b1;
          w_next = ST_EX;
        end
      end
      ST_EX: begin
        if (r_ex_cnt != ex_cycles) begin
          w_ex_cnt_nxt = r_ex_cnt + EXC_W'(1);
        end else begin
          w_ex_cnt_nxt = '0;
          if (halt_inst) begin
            w_next = ST_HALT;
          end else if (mem_inst) begin
            ex_to_mem_wen = 1'b1;
            w_next        = ST_MEM;
          end else begin
            pc_wen  = 1'b1;
            psr_wen = 1'b1;
            rf_wen  = 1'b1;
            w_next  = ST_IF;
          end
        end
      end
      ST_MEM: begin
        // mem_ready takes precedence over an expiring wait
        if (mem_ready) begin
          rf_wen     = 1'b1;
          pc_wen     = 1'b1;
          w_wait_nxt = '0;
          w_next     = ST_IF;
        end else if (r_wait_cnt < c_TIMEOUT) begin
          w_wait_nxt = r_wait_cnt + c_WAIT_W'(1);
        end else begin
          mem_timeout = 1'b1;
          pc_wen      = 1'b1;
          w_wait_nxt  = '0;
          w_next      = ST_IF;
        end
      end
      ST_HALT: begin
        halted = 1'b1;
        if (run) begin
          w_next = ST_IF;
        end
      end
      default: begin
        w_next = ST_IF;
      end
    endcase
  end

  assign stage = r_state;

`ifdef STAGE_SEQ_PERF_EN
  logic             w_retire;
  logic             w_stall;
  logic [CNT_W-1:0] r_instr_count;
  logic [CNT_W-1:0] r_stall_count;

  assign w_retire = ((r_state == ST_EX) && (r_ex_cnt == ex_cycles) && !halt_inst && !mem_inst)
                  || ((r_state == ST_MEM) && mem_ready);
  assign w_stall  = ((r_state == ST_IF) && !imem_ready) || ((r_state == ST_MEM) && !mem_ready);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_instr_count <= '0;
      r_stall_count <= '0;
    end else begin
      if (w_retire && (r_instr_count != '1)) begin
        r_instr_count <= r_instr_count + CNT_W'(1);
      end
      if (w_stall && (r_stall_count != '1)) begin
        r_stall_count <= r_stall_count + CNT_W'(1);
      end
    end
  end

  assign instr_count = r_instr_count;
  assign stall_count = r_stall_count;
`else
  assign instr_count = '0;
  assign stall_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stage_sequencer.sv
`default_nettype none
// Self-checking bench for stage_sequencer: per-cycle model compare plus
// directed sequences with hand-computed stage/enable literals.
module tb_stage_sequencer;

  localparam int EXC_W   = 3;
  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 32;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             imem_ready = 1'b0;
  logic             mem_inst = 1'b0;
  logic             halt_inst = 1'b0;
  logic [EXC_W-1:0] ex_cycles = '0;
  logic             mem_ready = 1'b0;
  logic             run = 1'b0;
  logic             ir_wen, ex_to_mem_wen, pc_wen, psr_wen, rf_wen;
  logic [1:0]       stage;
  logic             halted, mem_timeout;
  logic [CNT_W-1:0] instr_count, stall_count;

  stage_sequencer #(.EXC_W(EXC_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .resetn(resetn), .imem_ready(imem_ready), .mem_inst(mem_inst),
    .halt_inst(halt_inst), .ex_cycles(ex_cycles), .mem_ready(mem_ready), .run(run),
    .ir_wen(ir_wen), .ex_to_mem_wen(ex_to_mem_wen), .pc_wen(pc_wen), .psr_wen(psr_wen),
    .rf_wen(rf_wen), .stage(stage), .halted(halted), .mem_timeout(mem_timeout),
    .instr_count(instr_count), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

`ifdef STAGE_SEQ_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  task automatic chk(input string nm, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  int     m_st = 0, m_exc = 0, m_wc = 0;
  longint m_ic = 0, m_sc = 0;
  int     n_st = 0, n_exc = 0, n_wc = 0;
  longint n_ic = 0, n_sc = 0;
  longint cmax = (longint'(1) << CNT_W) - 1;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_st = 0; m_exc = 0; m_wc = 0; m_ic = 0; m_sc = 0;
    end else begin
      m_st = n_st; m_exc = n_exc; m_wc = n_wc; m_ic = n_ic; m_sc = n_sc;
    end
  end

  always @(negedge clk) begin
    int e_st;
    bit e_ir, e_exm, e_pc, e_psr, e_rf, e_h, e_to, ret, stl;
    e_st = m_st; e_ir = 0; e_exm = 0; e_pc = 0; e_psr = 0; e_rf = 0; e_h = 0; e_to = 0;
    ret = 0; stl = 0;
    n_st = m_st; n_exc = m_exc; n_wc = m_wc;
    if (!resetn) begin
      e_st = 0; e_ir = imem_ready;
      n_st = 0; n_exc = 0; n_wc = 0;
    end else begin
      if (m_st == 0) begin
        if (imem_ready) begin e_ir = 1; n_st = 1; end
        else stl = 1;
      end else if (m_st == 1) begin
        if (m_exc < int'(ex_cycles)) n_exc = m_exc + 1;
        else begin
          n_exc = 0;
          if (halt_inst) n_st = 3;
          else if (mem_inst) begin e_exm = 1; n_st = 2; end
          else begin e_pc = 1; e_psr = 1; e_rf = 1; n_st = 0; ret = 1; end
        end
      end else if (m_st == 2) begin
        if (mem_ready) begin e_rf = 1; e_pc = 1; n_wc = 0; n_st = 0; ret = 1; end
        else begin
          stl = 1;
          if (m_wc < TIMEOUT) n_wc = m_wc + 1;
          else begin e_to = 1; e_pc = 1; n_wc = 0; n_st = 0; end
        end
      end else begin
        e_h = 1;
        if (run) n_st = 0;
      end
    end
    n_ic = (!resetn) ? 0 : ((ret && m_ic < cmax) ? m_ic + 1 : m_ic);
    n_sc = (!resetn) ? 0 : ((stl && m_sc < cmax) ? m_sc + 1 : m_sc);
    chk("mon_stage", stage, e_st);
    chk("mon_ir_wen", ir_wen, e_ir);
    chk("mon_ex_to_mem_wen", ex_to_mem_wen, e_exm);
    chk("mon_pc_wen", pc_wen, e_pc);
    chk("mon_psr_wen", psr_wen, e_psr);
    chk("mon_rf_wen", rf_wen, e_rf);
    chk("mon_halted", halted, e_h);
    chk("mon_mem_timeout", mem_timeout, e_to);
    chk("mon_instr_count", instr_count, PERF ? m_ic : 0);
    chk("mon_stall_count", stall_count, PERF ? m_sc : 0);
  end

  // ---------------- directed stimulus ----------------
  longint s_ic, s_sc;

  // vec = {ir, ex_to_mem, pc, psr, rf, halted, mem_timeout}
  task automatic lit(input string nm, input int st, input logic [6:0] vec);
    chk({nm, "_stage"}, stage, st);
    chk({nm, "_outs"}, {ir_wen, ex_to_mem_wen, pc_wen, psr_wen, rf_wen, halted, mem_timeout}, vec);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input string nm, input int st, input logic [6:0] vec);
    @(negedge clk);
    lit(nm, st, vec);
    adv();
  endtask

  task automatic snap();
    s_ic = longint'(instr_count);
    s_sc = longint'(stall_count);
  endtask

  initial begin
    // reset state
    @(negedge clk);
    lit("rst", 0, 7'b0000000);
    chk("rst_ic", instr_count, 0);
    chk("rst_sc", stall_count, 0);
    imem_ready = 1;
    #1;
    lit("rst_ir_follow", 0, 7'b1000000);
    adv();
    resetn = 1;

    // ALU, ex_cycles=0
    cyc("alu_if", 0, 7'b1000000);
    cyc("alu_ex", 1, 7'b0011100);
    imem_ready = 0;
    cyc("idle0", 0, 7'b0000000);

    // load, ex_cycles=3, two mem_ready-low cycles
    imem_ready = 1; ex_cycles = 3; mem_inst = 1;
    @(negedge clk); snap(); lit("ld_if", 0, 7'b1000000); adv();
    for (int i = 0; i < 3; i++) cyc("ld_ex", 1, 7'b0000000);
    cyc("ld_ex_last", 1, 7'b0100000);
    mem_ready = 0;
    cyc("ld_mw0", 2, 7'b0000000);
    cyc("ld_mw1", 2, 7'b0000000);
    mem_ready = 1;
    cyc("ld_mem", 2, 7'b0010100);
    mem_ready = 0; imem_ready = 0; mem_inst = 0; ex_cycles = 0;
    @(negedge clk);
    chk("ld_ic_delta", longint'(instr_count) - s_ic, PERF ? 1 : 0);
    chk("ld_sc_delta", longint'(stall_count) - s_sc, PERF ? 2 : 0);
    lit("idle1", 0, 7'b0000000);
    adv();

    // MEM timeout: 5 MEM cycles, abort on the 5th
    imem_ready = 1; mem_inst = 1;
    @(negedge clk); snap(); lit("to_if", 0, 7'b1000000); adv();
    cyc("to_ex", 1, 7'b0100000);
    for (int i = 0; i < TIMEOUT; i++) cyc("to_wait", 2, 7'b0000000);
    cyc("to_abort", 2, 7'b0010001);
    imem_ready = 0; mem_inst = 0;
    @(negedge clk);
    chk("to_ic_delta", longint'(instr_count) - s_ic, 0);
    chk("to_sc_delta", longint'(stall_count) - s_sc, PERF ? 5 : 0);
    lit("idle2", 0, 7'b0000000);
    adv();

    // mem_ready on the last permitted cycle wins over timeout
    imem_ready = 1; mem_inst = 1;
    cyc("rw_if", 0, 7'b1000000);
    cyc("rw_ex", 1, 7'b0100000);
    for (int i = 0; i < TIMEOUT; i++) cyc("rw_wait", 2, 7'b0000000);
    mem_ready = 1;
    cyc("rw_ready_wins", 2, 7'b0010100);
    mem_ready = 0; imem_ready = 0; mem_inst = 0;

    // HALT; run ignored outside HALT
    run = 1;
    cyc("run_in_if", 0, 7'b0000000);
    imem_ready = 1;
    cyc("h_if", 0, 7'b1000000);
    run = 0; imem_ready = 0; halt_inst = 1; mem_inst = 1;
    cyc("h_ex", 1, 7'b0000000);
    cyc("h_halt0", 3, 7'b0000010);
    cyc("h_halt1", 3, 7'b0000010);
    run = 1;
    cyc("h_run", 3, 7'b0000010);
    run = 0; halt_inst = 0; mem_inst = 0;
    cyc("h_back", 0, 7'b0000000);

    // reset in the middle of a MEM wait (wait count 2)
    imem_ready = 1; mem_inst = 1;
    cyc("rm_if", 0, 7'b1000000);
    cyc("rm_ex", 1, 7'b0100000);
    imem_ready = 0; mem_ready = 0;
    cyc("rm_w0", 2, 7'b0000000);
    cyc("rm_w1", 2, 7'b0000000);
    @(negedge clk);
    lit("rm_w2", 2, 7'b0000000);
    #2;
    mem_ready = 1; resetn = 0;
    #1;
    lit("rm_rst", 0, 7'b0000000);
    adv();
    resetn = 1; mem_ready = 0; mem_inst = 0;
    @(negedge clk);
    chk("rm_ic_zero", instr_count, 0);
    chk("rm_sc_zero", stall_count, 0);
    lit("rm_idle", 0, 7'b0000000);
    adv();

    // ten ALU retirements with varied ex_cycles
    imem_ready = 1;
    for (int i = 0; i < 10; i++) begin
      ex_cycles = EXC_W'(i % 3);
      cyc("l_if", 0, 7'b1000000);
      for (int j = 0; j < i % 3; j++) cyc("l_ex", 1, 7'b0000000);
      cyc("l_ex_last", 1, 7'b0011100);
    end
    imem_ready = 0;
    @(negedge clk);
    chk("loop_ic", instr_count, PERF ? 10 : 0);
    chk("loop_sc", stall_count, PERF ? 1 : 0);
    adv();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/stage_sequencer.md
# stage_sequencer

Parametrised multicycle stage controller for the processor datapath. It sequences each instruction through IF, EX and an optional MEM stage, and generates the write enables for IR, the EX→MEM pipeline register, PC, PSR and the register file. Compared with the fixed three-stage controller, it adds:
- handshake waits on instruction and data memory;
- programmable multi-cycle execute;
- a bounded MEM wait with timeout abort;
- a HALT state.

## Interface
Parameters:
- EXC_W, 3: width of ex_cycles.
- TIMEOUT, 15: maximum MEM wait cycles before abort; legal range is ≥1.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- imem_ready  in  1  fetch data valid this cycle.
- mem_inst  in  1  decoded instruction needs MEM; sampled in EX.
- halt_inst  in  1  decoded instruction is HALT; sampled in EX.
- ex_cycles  in  EXC_W  extra execute cycles; 0 means single-cycle EX; stable while in EX.
- mem_ready  in  1  data memory access complete this cycle.
- run  in  1  resume from HALT; ignored in all other states.
- ir_wen  out  1  IR write enable.
- ex_to_mem_wen  out  1  EX→MEM register write enable.
- pc_wen  out  1  PC write enable.
- psr_wen  out  1  PSR write enable.
- rf_wen  out  1  register file write enable.
- stage  out  2  current state: IF=0, EX=1, MEM=2, HALT=3.
- halted  out  1  high while in HALT.
- mem_timeout  out  1  one-cycle pulse when a MEM wait aborts.
- instr_count  out  CNT_W  retired instruction count.
- stall_count  out  CNT_W  memory wait cycle count.

## Operation
- **Registered state:**
  - state, 2 bits;
  - ex_cnt, EXC_W bits;
  - wait_cnt, $clog2(TIMEOUT+1) bits;
  - the performance counters.
- **Outputs:** all enables and mem_timeout are combinational from state and current inputs. Any enable not listed for a state/condition is 0.
- **IF:**
  - imem_ready=0: stay in IF.
  - imem_ready=1: ir_wen=1, go to EX.
- **EX:**
  - ex_cnt≠ex_cycles: ex_cnt increments, stay in EX, no enables.
  - ex_cnt==ex_cycles: the instruction completes EX; ex_cnt clears to 0. Priority order:
    - halt_inst=1: go to HALT, no enables.
    - else mem_inst=1: ex_to_mem_wen=1, go to MEM.
    - else: pc_wen=psr_wen=rf_wen=1, go to IF; the instruction retires.
- **MEM:** wait_cnt is 0 in the first MEM cycle.
  - mem_ready=1: rf_wen=1, pc_wen=1, wait_cnt clears, go to IF; the instruction retires.
  - mem_ready=0 and wait_cnt<TIMEOUT: wait_cnt increments, stay in MEM.
  - mem_ready=0 and wait_cnt==TIMEOUT: mem_timeout=1, pc_wen=1, rf_wen=0, wait_cnt clears, go to IF. The instruction is skipped and does not retire.
  - mem_ready=1 and wait_cnt==TIMEOUT together: ready wins, no timeout.
- **HALT:**
  - All enables are 0 and halted=1.
  - run=1: go to IF.
- **Reset (asserted at any time, including mid-EX or mid-MEM):**
  - state goes to IF; ex_cnt, wait_cnt and both counters go to 0.
  - Output values during reset: ir_wen follows imem_ready. ex_to_mem_wen, pc_wen, psr_wen, rf_wen, halted and mem_timeout are 0. stage=0.
  - An in-flight instruction is discarded with no writes.
- **Illegal state:** none exists; all 2-bit encodings are used.

## Timing
- Latency from IF entry to retirement, with ready inputs high and ex_cycles=E:
  - ALU instruction: 2+E cycles.
  - Memory instruction: 3+E cycles, plus one cycle per mem_ready-low MEM cycle.
- An instruction that times out occupies MEM for exactly TIMEOUT+1 cycles.
- A HALT instruction reaches the HALT state 1+E cycles after leaving IF. After the run cycle, IF begins on the next cycle.
- The decoded inputs (mem_inst, halt_inst, ex_cycles) only need to be valid in EX. They come from IR, which is written at the end of IF.

## Configuration
- STAGE_SEQ_PERF_EN defined:
  - instr_count increments by 1 on each retirement cycle (EX non-mem completion, or MEM completion with mem_ready).
  - stall_count increments on each cycle in IF with imem_ready=0, or in MEM with mem_ready=0.
  - Both counters saturate at all-ones; a timeout does not increment instr_count.
- STAGE_SEQ_PERF_EN undefined:
  - Both ports remain present and are driven constant 0; no counter flops are synthesised.

## Test plan
- ALU instruction, imem_ready=1, ex_cycles=0, mem_inst=0 -> stage 0,1,0. ir_wen is high in cycle 1; pc_wen, psr_wen and rf_wen are high in cycle 2.
- ex_cycles=3, load instruction, mem_ready low for 2 cycles -> stage 0,1,1,1,1,2,2,2,0. ex_to_mem_wen is high in the last EX cycle; rf_wen and pc_wen are high in the third MEM cycle. With perf enabled: stall_count=2, instr_count=1.
- TIMEOUT=4, mem_ready held 0 -> 5 MEM cycles; mem_timeout pulses once in the 5th cycle with pc_wen=1 and rf_wen=0; then IF; instr_count unchanged.
- halt_inst=1 together with mem_inst=1 -> HALT entered, no enables, halted=1. run ignored in IF; run=1 in HALT -> IF on the next cycle.
- resetn pulsed low during MEM wait_cnt=2 -> stage=0 immediately; no rf_wen or pc_wen; counters are 0 after release.
- Macro undefined -> instr_count and stall_count read 0 after 10 retired instructions.
